// File: rtl/bank_dump_ctrl_pkg.sv
// Shared defaults, FSM state encoding and dump-bundle sizing for the bank dump controller.
package bank_dump_ctrl_pkg;

    localparam int DATA_W_DEF  = 16;
    localparam int DEPTH_DEF   = 256;
    localparam int ROW_LEN_DEF = 64;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        DUMP  = 2'd2
    } state_e;

    // A dump word travels as {data, addr, row_end, last}.
    function automatic int bundleWidth(input int dataW, input int addrW);
        return dataW + addrW + 2;
    endfunction

endpackage

// File: rtl/bank_dump_skid.sv
// Two-entry valid/ready skid buffer; inReady_o comes straight from a flop so upstream
// timing stays short while one word per cycle still flows when the sink keeps ready high.
module bank_dump_skid
    import bank_dump_ctrl_pkg::*;
#(
    parameter int WIDTH = bundleWidth(DATA_W_DEF, $clog2(DEPTH_DEF))
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inValid_i,
    output logic             inReady_o,
    input  logic [WIDTH-1:0] inData_i,
    output logic             outValid_o,
    input  logic             outReady_i,
    output logic [WIDTH-1:0] outData_o
);

    logic             outValid_q;
    logic             skidValid_q;
    logic [WIDTH-1:0] outData_q;
    logic [WIDTH-1:0] skidData_q;
    logic             inFire;
    logic             outFree;

    assign inReady_o  = !skidValid_q;
    assign inFire     = inValid_i && !skidValid_q;
    assign outFree    = !outValid_q || outReady_i;
    assign outValid_o = outValid_q;
    assign outData_o  = outData_q;

    // The skid entry only fills when the output is stalled; it always drains first.
    always_ff @(posedge clk) begin
        if (reset) begin
            outValid_q  <= 1'b0;
            skidValid_q <= 1'b0;
            outData_q   <= '0;
            skidData_q  <= '0;
        end else if (outFree) begin
            if (skidValid_q) begin
                outData_q   <= skidData_q;
                outValid_q  <= 1'b1;
                skidValid_q <= 1'b0;
            end else if (inFire) begin
                outData_q  <= inData_i;
                outValid_q <= 1'b1;
            end else begin
                outValid_q <= 1'b0;
            end
        end else if (inFire) begin
            skidData_q  <= inData_i;
            skidValid_q <= 1'b1;
        end
    end

endmodule

// File: rtl/bank_dump_ctrl.sv
// Single-bank data memory with a host read/write port, a post-reset clear sweep and a
// dump engine that streams every word out in ascending address order over valid/ready.
module bank_dump_ctrl
    import bank_dump_ctrl_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int ADDR_W  = $clog2(DEPTH),
    parameter int ROW_LEN = ROW_LEN_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    input  logic              read_enable,
    input  logic              write_enable,
    output logic [DATA_W-1:0] data_out,
    output logic              busy,
    input  logic              dump_req,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [DATA_W-1:0] dump_data,
    output logic [ADDR_W-1:0] dump_addr,
    output logic              dump_row_end,
    output logic              dump_last,
    output logic              dump_done
);

    localparam int                BUNDLE_W  = bundleWidth(DATA_W, ADDR_W);
    localparam int                ROW_W     = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROW_LEN - 1);

    logic [DATA_W-1:0] mem [DEPTH];

    state_e            state_q;
    logic              busy_q;
    logic              pending_q;
    logic              dumpDone_q;
    logic [DATA_W-1:0] dataOut_q;
    logic [ADDR_W-1:0] clrPtr_q;
    logic [ADDR_W-1:0] issuePtr_q;
    logic [ROW_W-1:0]  rowCnt_q;
    logic              issueDone_q;

    logic                hostInRange;
    logic                memWe;
    logic [ADDR_W-1:0]   memWaddr;
    logic [DATA_W-1:0]   memWdata;
    logic                skidInReady;
    logic                issueFire;
    logic [BUNDLE_W-1:0] issueBundle;
    logic [BUNDLE_W-1:0] outBundle;
    logic                outValid;
    logic                outFire;

    assign hostInRange = {1'b0, addr} < DEPTH_X;

    // The clear sweep owns the write port; host writes only land outside CLEAR.
    always_comb begin
        memWe    = 1'b0;
        memWaddr = addr;
        memWdata = data_in;
        if (state_q == CLEAR) begin
            memWe    = 1'b1;
            memWaddr = clrPtr_q;
            memWdata = '0;
        end else if (write_enable && hostInRange) begin
            memWe = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (memWe && !reset) begin
            mem[memWaddr] <= memWdata;
        end
    end

    // Host read sees the pre-write contents when read and write hit the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            dataOut_q <= '0;
        end else begin
            dataOut_q <= (read_enable && hostInRange && state_q != CLEAR) ? mem[addr] : '0;
        end
    end

    assign issueFire   = (state_q == DUMP) && !issueDone_q && skidInReady;
    assign issueBundle = {mem[issuePtr_q], issuePtr_q, rowCnt_q == ROW_LAST, issuePtr_q == LAST_ADDR};

    bank_dump_skid #(
        .WIDTH (BUNDLE_W)
    ) u_skid (
        .clk        (clk),
        .reset      (reset),
        .inValid_i  (issueFire),
        .inReady_o  (skidInReady),
        .inData_i   (issueBundle),
        .outValid_o (outValid),
        .outReady_i (dump_ready),
        .outData_o  (outBundle)
    );

    assign outFire = outValid && dump_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= CLEAR;
            busy_q      <= 1'b1;
            pending_q   <= 1'b0;
            dumpDone_q  <= 1'b0;
            clrPtr_q    <= '0;
            issuePtr_q  <= '0;
            rowCnt_q    <= '0;
            issueDone_q <= 1'b0;
        end else begin
            dumpDone_q <= 1'b0;
            case (state_q)
                CLEAR: begin
                    if (dump_req) begin
                        pending_q <= 1'b1;
                    end
                    if (clrPtr_q == LAST_ADDR) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        clrPtr_q <= clrPtr_q + ADDR_W'(1);
                    end
                end
                IDLE: begin
                    if (dump_req || pending_q) begin
                        state_q     <= DUMP;
                        pending_q   <= 1'b0;
                        issuePtr_q  <= '0;
                        rowCnt_q    <= '0;
                        issueDone_q <= 1'b0;
                    end
                end
                DUMP: begin
                    // Row position is tracked by a counter so no divider is needed for odd ROW_LEN.
                    if (issueFire) begin
                        if (issuePtr_q == LAST_ADDR) begin
                            issueDone_q <= 1'b1;
                        end else begin
                            issuePtr_q <= issuePtr_q + ADDR_W'(1);
                        end
                        rowCnt_q <= (rowCnt_q == ROW_LAST) ? '0 : rowCnt_q + ROW_W'(1);
                    end
                    if (outFire && outBundle[0]) begin
                        state_q    <= IDLE;
                        dumpDone_q <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= CLEAR;
                    busy_q   <= 1'b1;
                    clrPtr_q <= '0;
                end
            endcase
        end
    end

    assign data_out     = dataOut_q;
    assign busy         = busy_q;
    assign dump_done    = dumpDone_q;
    assign dump_valid   = outValid;
    assign dump_data    = outBundle[BUNDLE_W-1 -: DATA_W];
    assign dump_addr    = outBundle[2 +: ADDR_W];
    assign dump_row_end = outBundle[1];
    assign dump_last    = outBundle[0];

endmodule
